// File: rtl/csm51a_pkg.sv
// ---------------------------------------------------------------------------
// csm51a_pkg
// Shared definitions for the 2-bit symbol link (transmitter and detector
// bench): FSM state encodings and the idle symbol value.
// ---------------------------------------------------------------------------
package csm51a_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Symbol driven on x1/x0 whenever no frame symbol is present.
  localparam logic [1:0] SYM_IDLE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SEND = S_SEND,
    ST_GAP  = S_GAP
  } state_t;

endpackage

// File: rtl/csm51a_sym_shreg.sv
// ---------------------------------------------------------------------------
// csm51a_sym_shreg
// Parallel-load shift register holding NSYM 2-bit symbols. Symbol 0 sits in
// the low two bits and is presented on o_sym; each shift moves the next
// symbol down and fills the top with idle symbols.
// Ports:
//   i_clock    rising-edge clock
//   i_clear_n  asynchronous active-low clear
//   i_load     load i_data (has priority over shift)
//   i_shift    shift right by one symbol
//   i_data     parallel frame, 2*NSYM bits
//   o_sym      current symbol (low two bits of the register)
// ---------------------------------------------------------------------------
module csm51a_sym_shreg
  import csm51a_pkg::*;
#(
  parameter int NSYM = 8
) (
  input  logic              i_clock,
  input  logic              i_clear_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [2*NSYM-1:0] i_data,
  output logic [1:0]        o_sym
);

  logic [2*NSYM-1:0] r_data;

  // Symbol storage: load wins over shift; zeros shift in from the top.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_data <= {NSYM{SYM_IDLE}};
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= r_data >> 2;
    end else begin
      r_data <= r_data;
    end
  end

  assign o_sym = r_data[1:0];

endmodule

// File: rtl/csm51a_symbol_tx.sv
// ---------------------------------------------------------------------------
// csm51a_symbol_tx
// Transmit end of the 2-bit symbol link. Accepts a frame of up to NSYM
// symbols over valid/ready, sends one symbol per clock on x1/x0, then sends
// GAP_CYCLES idle cycles, pulses done and bumps frames_sent.
// Ports:
//   clock, clear_n     clock and asynchronous active-low reset
//   load_valid/ready   frame handshake (ready only in IDLE)
//   load_data          symbols, symbol i = load_data[2i+1:2i], 0 sent first
//   load_len           symbol count, clamped to NSYM, 0 = gap only
//   x1, x0             current symbol (registered, 0 outside a frame)
//   sym_valid          x1/x0 carry a frame symbol
//   busy               not in IDLE
//   done               one-cycle pulse in the first IDLE cycle after a gap
//   frames_sent        completed-frame count, wraps at 255
// ---------------------------------------------------------------------------
module csm51a_symbol_tx
  import csm51a_pkg::*;
#(
  parameter int NSYM       = 8,
  parameter int GAP_CYCLES = 2,
  parameter int LENW       = $clog2(NSYM + 1)
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [2*NSYM-1:0] load_data,
  input  logic [LENW-1:0]   load_len,
  output logic              x1,
  output logic              x0,
  output logic              sym_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frames_sent
);

  // Gap counter holds GAP_CYCLES-1 down to 0.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            r_state;
  logic [LENW-1:0]   r_cnt;
  logic [GW-1:0]     r_gap;
  logic              r_sym_valid;
  logic              r_done;
  logic [7:0]        r_frames;

  logic [LENW-1:0]   w_len;
  logic [2*NSYM-1:0] w_frame;
  logic              w_accept;
  logic              w_shift;
  logic [1:0]        w_sym;

  assign w_accept = load_valid && (r_state == ST_IDLE);
  assign w_shift  = (r_state == ST_SEND);

  // Clamp the length and blank symbols beyond it, so the shift register
  // empties to idle symbols exactly when the last symbol has been sent.
  always_comb begin
    w_len   = load_len;
    w_frame = '0;
    if (load_len > LENW'(NSYM)) begin
      w_len = LENW'(NSYM);
    end else begin
      w_len = load_len;
    end
    for (int i = 0; i < NSYM; i++) begin
      if (LENW'(i) < w_len) begin
        w_frame[2*i +: 2] = load_data[2*i +: 2];
      end else begin
        w_frame[2*i +: 2] = SYM_IDLE;
      end
    end
  end

  csm51a_sym_shreg #(
    .NSYM (NSYM)
  ) u_shreg (
    .i_clock   (clock),
    .i_clear_n (clear_n),
    .i_load    (w_accept),
    .i_shift   (w_shift),
    .i_data    (w_frame),
    .o_sym     (w_sym)
  );

  // Frame sequencing FSM with registered sym_valid/done/frame counter.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_sym_valid <= 1'b0;
      r_done      <= 1'b0;
      r_frames    <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_len != '0) begin
              r_state     <= ST_SEND;
              r_cnt       <= w_len;
              r_sym_valid <= 1'b1;
            end else begin
              r_state     <= ST_GAP;
              r_gap       <= GW'(GAP_CYCLES - 1);
              r_sym_valid <= 1'b0;
            end
          end else begin
            r_sym_valid <= 1'b0;
          end
        end
        ST_SEND: begin
          r_cnt <= r_cnt - LENW'(1);
          // Edge after the last symbol: enter the gap.
          if (r_cnt == LENW'(1)) begin
            r_state     <= ST_GAP;
            r_gap       <= GW'(GAP_CYCLES - 1);
            r_sym_valid <= 1'b0;
          end else begin
            r_sym_valid <= 1'b1;
          end
        end
        ST_GAP: begin
          r_sym_valid <= 1'b0;
          if (r_gap == '0) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b1;
            r_frames <= r_frames + 8'd1;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sym_valid <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready  = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign x1          = w_sym[1];
  assign x0          = w_sym[0];
  assign sym_valid   = r_sym_valid;
  assign done        = r_done;
  assign frames_sent = r_frames;

endmodule

// File: doc/csm51a_symbol_tx.md
Name: csm51a_symbol_tx

Overview:
- Transmit end of the 2-bit symbol link consumed by the lab-3 Mealy detector; the detector samples (x1,x0) once per clock.
- Accepts a parallel frame of up to NSYM 2-bit symbols over a valid/ready handshake.
- Serialises the frame one symbol per clock onto x1/x0, then drives GAP_CYCLES idle symbols (x0=0, no detector event).
- Reports completion with a done pulse and keeps a frame counter for the bench.

Parameters:
- NSYM, 8, maximum symbols per frame (>=1).
- GAP_CYCLES, 2, idle cycles appended after each frame (>=1).
- LENW, $clog2(NSYM+1), width of load_len.

Ports:
- clock  in  1  rising-edge system clock.
- clear_n  in  1  asynchronous active-low reset.
- load_valid  in  1  frame offered.
- load_ready  out  1  block can accept a frame.
- load_data  in  2*NSYM  symbols; symbol i = {load_data[2i+1], load_data[2i]} = {x1,x0}; symbol 0 is sent first.
- load_len  in  LENW  number of symbols to send.
- x1  out  1  current symbol high bit (registered).
- x0  out  1  current symbol low bit (registered).
- sym_valid  out  1  x1/x0 carry a frame symbol this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, first IDLE cycle after GAP.
- frames_sent  out  8  completed-frame count, wraps 255->0.

Behaviour:
- Reset (clear_n=0, asynchronous, any state): state=IDLE, shift reg=0, symbol count=0, gap count=0.
  - Outputs: x1=0, x0=0, sym_valid=0, done=0, frames_sent=0.
  - A frame in progress is abandoned. No done pulse on release.
- All outputs are registered. Only load_ready (= state==IDLE) and busy are combinational from state.
- Handshake: a frame is accepted at a rising edge where load_valid & load_ready. load_data and load_len are captured then. A load outside IDLE is ignored, not queued.
- load_len > NSYM is clamped to NSYM. load_len = 0 skips SEND and goes straight to GAP.
- FSM:
  - IDLE: x1=x0=0, sym_valid=0. On accept with len>0 -> SEND; on accept with len=0 -> GAP.
  - SEND: shift reg drives symbol 0 in the first cycle after the accept edge, so latency from accept edge to first symbol is 1 cycle. Each edge shifts right by 2 and decrements the remaining count. sym_valid=1 for exactly len cycles. The edge that emits the last symbol's successor moves to GAP.
  - GAP: x1=x0=0, sym_valid=0 for exactly GAP_CYCLES cycles, then -> IDLE. On that transition: done=1 for one cycle, frames_sent += 1.
- done and load_ready are both high in the first IDLE cycle, so a back-to-back accept there is legal.
- Minimum frame period = 1 + len + GAP_CYCLES cycles.
- x1/x0 hold 0 whenever sym_valid=0. Note that symbol 00 inside a frame is legal and is distinguished only by sym_valid.

Decomposition:
- Shared package csm51a_pkg:
  - state localparams S_IDLE=2'd0, S_SEND=2'd1, S_GAP=2'd2.
  - symbol constants SYM_IDLE=2'b00.
  - reused by the detector bench.
- One natural sub-module: csm51a_sym_shreg.
  - 2*NSYM parallel-load shift register with load and shift enables.
  - async active-low clear.
  - outputs the low 2 bits.
- The FSM, counters and done/frames_sent logic stay in csm51a_symbol_tx.

Test Plan (NSYM=8, GAP_CYCLES=2):
- Reset idle: hold clear_n=0 for 3 cycles, then release -> x1=x0=0, sym_valid=0, load_ready=1, busy=0, frames_sent=0.
- Basic frame: load_data=16'hB1E4, len=4, accepted at edge k.
  - Cycles k+1..k+4: {x1,x0} = 00,01,10,11 with sym_valid=1.
  - Cycles k+5..k+6: 00 with sym_valid=0.
  - done=1 in cycle k+7; frames_sent=1.
- Full and clamped length: load_data=16'hB1E4, len=8 -> 8 symbols 00,01,10,11,01,00,11,10. Repeat with len=15 -> identical 8 symbols (clamp).
- Zero length and back-to-back: len=0 -> GAP 2 cycles, done, frames_sent+1, no sym_valid. Keep load_valid high with a new frame -> accepted in the done cycle, next symbol follows 1 cycle later.
- Load while busy: assert load_valid with 16'hFFFF during SEND of the basic frame -> ignored, original symbols unchanged, load_ready=0 throughout.
- Reset mid-frame: pull clear_n low asynchronously during the 2nd symbol (between edges) -> outputs 0 immediately. After release: IDLE, no done, frames_sent=0.
